// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared FSM encoding and counter widths for the IF/DM memory port arbiter
package mem_port_arbiter_pkg;
  localparam int ARB_STARVE_W = 4;
  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_GRANT_IF = 2'd1,
    ARB_GRANT_DM = 2'd2,
    ARB_HALTED   = 2'd3
  } arb_state_e;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data path; optional stall counter under MEM_ARB_PERF_EN
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  input  logic              halt,
  output logic              stall_b,
  output logic              halted
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);
  localparam logic [ARB_STARVE_W-1:0] LIMIT = ARB_STARVE_W'(STARVE_LIMIT);
  arb_state_e              state_q, state_d;
  logic [ARB_STARVE_W-1:0] starve_q, starve_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]       mem_wdata_q, mem_wdata_d;
  logic                    pick_dm;
  assign pick_dm   = dm_req && !(if_req && starve_q == LIMIT);
  assign if_ack    = state_q == ARB_GRANT_IF && mem_ready;
  assign dm_ack    = state_q == ARB_GRANT_DM && mem_ready;
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign halted    = state_q == ARB_HALTED;
  assign stall_b   = !((if_req && !if_ack) || (dm_req && !dm_ack));
  // arbitration in IDLE, hold the registered access until mem_ready, then IDLE or HALTED
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ARB_IDLE:
        if (halt) state_d = ARB_HALTED;
        else if (pick_dm) begin
          state_d     = ARB_GRANT_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          starve_d    = if_req ? (starve_q == LIMIT ? starve_q : starve_q + 1'b1) : '0;
        end else if (if_req) begin
          state_d    = ARB_GRANT_IF;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          starve_d   = '0;
        end
      ARB_GRANT_IF, ARB_GRANT_DM:
        if (mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = halt ? ARB_HALTED : ARB_IDLE;
        end
      default: mem_req_d = 1'b0;
    endcase
  end
  // state and memory-port registers; reset abandons any in-flight access
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= ARB_IDLE;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end
`ifdef MEM_ARB_PERF_EN
  logic [31:0] stall_cnt_q;
  assign stall_cycles = stall_cnt_q;
  // saturating count of stalled cycles, frozen once halted
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) stall_cnt_q <= '0;
    else if (!stall_b && state_q != ARB_HALTED && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
  end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a latency-programmable memory responder
module tb_mem_port_arbiter;
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
  } txn_t;
  logic clk = 1'b0;
  logic rst_b;
  logic if_req, dm_req, dm_we, halt;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic if_ack, dm_ack, mem_req, mem_we, mem_ready, stall_b, halted;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] stall_cycles;
`endif
  int checks = 0;
  int errors = 0;
  int n_if = 0;
  int n_dm = 0;
  int lat = 0;
  int wait_cnt = 0;
  txn_t ifq[$];
  txn_t dmq[$];
  logic order[$];
  always #5 clk = ~clk;
  mem_port_arbiter dut (
    .clk(clk), .rst_b(rst_b),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .halt(halt), .stall_b(stall_b), .halted(halted)
`ifdef MEM_ARB_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a == 32'h40 ? 32'h8C22_0004 : {a[15:0], ~a[15:0]};
  endfunction
  assign mem_rdata = mem_val(mem_addr);
  assign mem_ready = mem_req && wait_cnt >= lat;
  always @(posedge clk) wait_cnt <= (mem_req && !mem_ready) ? wait_cnt + 1 : 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    txn_t t;
    if (if_ack) begin
      n_if++;
      order.push_back(1'b0);
      if (ifq.size() == 0) chk("if_spurious_ack", 1, 0);
      else begin
        t = ifq.pop_front();
        chk("if_mem_addr", mem_addr, t.addr);
        chk("if_mem_we", {31'd0, mem_we}, 0);
        chk("if_rdata", if_rdata, t.data);
      end
    end
    if (dm_ack) begin
      n_dm++;
      order.push_back(1'b1);
      if (dmq.size() == 0) chk("dm_spurious_ack", 1, 0);
      else begin
        t = dmq.pop_front();
        chk("dm_mem_addr", mem_addr, t.addr);
        chk("dm_mem_we", {31'd0, mem_we}, {31'd0, t.we});
        if (t.we) chk("dm_mem_wdata", mem_wdata, t.data);
        else chk("dm_rdata", dm_rdata, t.data);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue_if(input logic [31:0] a);
    txn_t t;
    if_addr = a;
    if_req  = 1'b1;
    t.addr = a; t.we = 1'b0; t.data = mem_val(a);
    ifq.push_back(t);
  endtask
  task automatic issue_dm(input logic we, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    dm_we    = we;
    dm_addr  = a;
    dm_wdata = d;
    dm_req   = 1'b1;
    t.addr = a; t.we = we; t.data = we ? d : mem_val(a);
    dmq.push_back(t);
  endtask
  task automatic wait_ack(input bit dm, input int budget);
    int start = dm ? n_dm : n_if;
    int k = 0;
    while ((dm ? n_dm : n_if) == start && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(dm ? "dm_ack_seen" : "if_ack_seen", {31'd0, (dm ? n_dm : n_if) != start}, 1);
    tick();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
  initial begin
    int lif, ldm, n_if0;
    rst_b = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; halt = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 0);
    chk("rst_mem_we", {31'd0, mem_we}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_halted", {31'd0, halted}, 0);
    chk("rst_stall_b", {31'd0, stall_b}, 1);
    rst_b = 1'b1;
    tick();
`ifdef MEM_ARB_PERF_EN
    lat = 2;
    issue_dm(1'b0, 32'h10, 32'h0);
    wait_ack(1'b1, 10);
    dm_req = 1'b0;
    @(negedge clk);
    chk("perf_stall3", stall_cycles, 3);
    repeat (3) tick();
    chk("perf_idle_hold", stall_cycles, 3);
    tick();
`endif
    lat = 0;
    issue_if(32'h40);
    @(negedge clk);
    chk("lf_idle_stall_b", {31'd0, stall_b}, 0);
    chk("lf_idle_ack", {31'd0, if_ack}, 0);
    chk("lf_idle_mem_req", {31'd0, mem_req}, 0);
    tick();
    @(negedge clk);
    chk("lf_mem_req", {31'd0, mem_req}, 1);
    chk("lf_mem_addr", mem_addr, 32'h40);
    chk("lf_if_ack", {31'd0, if_ack}, 1);
    chk("lf_if_rdata", if_rdata, 32'h8C22_0004);
    chk("lf_stall_b", {31'd0, stall_b}, 1);
    tick();
    if_req = 1'b0;
    @(negedge clk);
    chk("lf_done_mem_req", {31'd0, mem_req}, 0);
    tick();
    lat = 3;
    issue_dm(1'b1, 32'h100, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("st_idle_stall_b", {31'd0, stall_b}, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("st_hold_req", {31'd0, mem_req}, 1);
      chk("st_hold_addr", mem_addr, 32'h100);
      chk("st_hold_we", {31'd0, mem_we}, 1);
      chk("st_hold_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("st_hold_ack", {31'd0, dm_ack}, 0);
      chk("st_hold_stall_b", {31'd0, stall_b}, 0);
    end
    tick();
    @(negedge clk);
    chk("st_ack", {31'd0, dm_ack}, 1);
    chk("st_ack_stall_b", {31'd0, stall_b}, 1);
    tick();
    dm_req = 1'b0;
    tick();
    lat = 0;
    order.delete();
    issue_if(32'h1000);
    issue_dm(1'b0, 32'h2000, 32'h0);
    lif = n_if; ldm = n_dm;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (n_if + n_dm - lif - ldm >= 10) break;
      if (n_dm != ldm + (order.size() - (n_if - lif))) begin end
      if (n_if - lif != ifq.size() - 1 + (n_if - lif) && ifq.size() == 0) issue_if(if_addr + 32'h4);
      if (dmq.size() == 0) issue_dm(1'b0, dm_addr + 32'h4, 32'h0);
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    ifq.delete();
    dmq.delete();
    chk("cont_ack_count", order.size(), 10);
    for (int i = 0; i < 10 && i < order.size(); i++)
      chk($sformatf("cont_order_%0d", i), {31'd0, order[i]}, (i % 5 == 4) ? 32'd0 : 32'd1);
    tick();
    lat = 2;
    issue_dm(1'b0, 32'h200, 32'h0);
    issue_if(32'h300);
    tick();
    halt = 1'b1;
    @(negedge clk);
    chk("hl_grant_dm", {31'd0, mem_req && mem_addr == 32'h200}, 1);
    chk("hl_c1_ack", {31'd0, dm_ack}, 0);
    tick();
    @(negedge clk);
    chk("hl_c2_ack", {31'd0, dm_ack}, 0);
    tick();
    @(negedge clk);
    chk("hl_dm_ack", {31'd0, dm_ack}, 1);
    tick();
    dm_req = 1'b0;
    n_if0 = n_if;
    @(negedge clk);
    chk("hl_halted", {31'd0, halted}, 1);
    chk("hl_mem_req", {31'd0, mem_req}, 0);
    chk("hl_stall_b", {31'd0, stall_b}, 0);
    repeat (5) tick();
    chk("hl_no_if_ack", n_if, n_if0);
    chk("hl_still_halted", {31'd0, halted}, 1);
    ifq.delete();
    if_req = 1'b0;
    halt = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    chk("rm_unhalted", {31'd0, halted}, 0);
    lat = 5;
    tick();
    issue_if(32'h80);
    tick();
    @(negedge clk);
    chk("rm_grant_req", {31'd0, mem_req}, 1);
    chk("rm_grant_addr", mem_addr, 32'h80);
    n_if0 = n_if;
    #2 rst_b = 1'b0;
    #1;
    chk("rm_async_req", {31'd0, mem_req}, 0);
    chk("rm_async_addr", mem_addr, 0);
    chk("rm_no_ack", {31'd0, if_ack}, 0);
    #1 rst_b = 1'b1;
    chk("rm_no_ack_count", n_if, n_if0);
    lat = 0;
    wait_ack(1'b0, 10);
    if_req = 1'b0;
    repeat (2) tick();
    chk("end_queues_empty", ifq.size() + dmq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
